// File: rtl/func_scheduler_pkg.sv
// ============================================================================
// Module : func_scheduler_pkg
// Brief  : Shared FSM state encoding, response record and default width.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package func_scheduler_pkg;

  localparam int DEF_WIDTH = 10;
  localparam int MAX_ID_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_X    = 2'd1,
    ST_Y    = 2'd2,
    ST_Z    = 2'd3
  } state_e;

  // Response record at the default width; id is sized for the largest N_REQ (8).
  typedef struct packed {
    logic [MAX_ID_W-1:0]  id;
    logic [DEF_WIDTH-1:0] ret;
    logic [DEF_WIDTH-1:0] b;
    logic [DEF_WIDTH-1:0] c;
  } rsp_t;

endpackage

`default_nettype wire

// File: rtl/func_scheduler_rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin arbiter; search starts at ptr, one-hot out.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);

  logic w_found;
  int   w_idx;

  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 0; i < N; i++) begin
      w_idx = int'(ptr) + i;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/func_scheduler.sv
// ============================================================================
// Module : func_scheduler
// Brief  : Round-robin scheduler feeding a 3-step function unit (b, ret, c).
//          Optional grant counter enabled by macro FUNC_SCHEDULER_STATS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module func_scheduler
  import func_scheduler_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_REQ = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [N_REQ-1:0]           i_req_valid,
  output logic [N_REQ-1:0]           o_req_ready,
  input  logic [N_REQ*WIDTH-1:0]     i_req_a,
  input  logic [N_REQ*32-1:0]        i_req_d,
  output logic                       o_rsp_valid,
  input  logic                       i_rsp_ready,
  output logic [$clog2(N_REQ)-1:0]   o_rsp_id,
  output logic [WIDTH-1:0]           o_rsp_ret,
  output logic [WIDTH-1:0]           o_rsp_b,
  output logic [WIDTH-1:0]           o_rsp_c,
`ifdef FUNC_SCHEDULER_STATS_EN
  output logic [15:0]                o_grant_count,
`endif
  output logic                       o_busy
);

  localparam int IDW = $clog2(N_REQ);

  state_e           state_q, state_d;
  logic [IDW-1:0]   p_q, p_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] ret_q, ret_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;

  logic [N_REQ-1:0] w_grant;
  logic [IDW-1:0]   w_win;
  logic             w_take;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req   (i_req_valid),
    .ptr   (p_q),
    .grant (w_grant)
  );

  always_comb begin
    w_win = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_grant[k]) w_win = IDW'(k);
    end
  end

  assign w_take = (state_q == ST_IDLE) && (|i_req_valid);

  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    id_d        = id_q;
    a_d         = a_q;
    d_d         = d_q;
    ret_d       = ret_q;
    b_d         = b_q;
    c_d         = c_q;
    o_req_ready = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (w_take) begin
          o_req_ready = i_rst ? '0 : w_grant;
          id_d        = w_win;
          a_d         = i_req_a[int'(w_win)*WIDTH +: WIDTH];
          // Only the low WIDTH bits of d can influence a result taken mod 2^WIDTH.
          d_d         = WIDTH'(i_req_d[int'(w_win)*32 +: 32]);
          p_d         = (int'(w_win) == N_REQ-1) ? '0 : w_win + 1'b1;
          state_d     = ST_X;
        end
      end
      ST_X: begin
        b_d     = a_q + WIDTH'(1) + d_q;
        state_d = ST_Y;
      end
      ST_Y: begin
        ret_d   = a_q + WIDTH'(2);
        c_d     = a_q;
        state_d = ST_Z;
      end
      ST_Z: begin
        if (i_rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
      id_q    <= '0;
      a_q     <= '0;
      d_q     <= '0;
      ret_q   <= '0;
      b_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      id_q    <= id_d;
      a_q     <= a_d;
      d_q     <= d_d;
      ret_q   <= ret_d;
      b_q     <= b_d;
      c_q     <= c_d;
    end
  end

  assign o_rsp_valid = (state_q == ST_Z);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_rsp_id    = id_q;
  assign o_rsp_ret   = ret_q;
  assign o_rsp_b     = b_q;
  assign o_rsp_c     = c_q;

`ifdef FUNC_SCHEDULER_STATS_EN
  logic [15:0] grant_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      grant_cnt_q <= '0;
    end else if (w_take && (grant_cnt_q != 16'hFFFF)) begin
      grant_cnt_q <= grant_cnt_q + 16'd1;
    end
  end

  assign o_grant_count = grant_cnt_q;
`endif

endmodule

`default_nettype wire
